seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider built on the team's add/sub datapath (trial subtract = A + ~B + 1).
- Computes quotient and remainder of `dividend_in / divisor_in` with a start/done handshake.
- Sits beside the combinational add/sub units as the iterative arithmetic block, for paths where a single-cycle divide would not close timing.

Parameters:
- `WIDTH`, default 4: operand, quotient and remainder width in bits; legal values ≥ 2.

Ports:
- `clk_in` — input — 1 — clock; all state updates on the rising edge.
- `rst_n_in` — input — 1 — asynchronous active-low reset.
- `start_in` — input — 1 — request; sampled on a rising edge, accepted only in IDLE or DONE.
- `dividend_in` — input — WIDTH — unsigned dividend; latched on the accepting edge.
- `divisor_in` — input — WIDTH — unsigned divisor; latched on the accepting edge.
- `busy_out` — output — 1 — high while in CALC.
- `done_out` — output — 1 — one-cycle pulse; results valid this cycle.
- `quotient_out` — output — WIDTH — quotient; held until the next completion.
- `remainder_out` — output — WIDTH — remainder; held until the next completion.
- `div_by_zero_out` — output — 1 — set with done when the divisor is 0; held with the results.

Behaviour:
- Reset (`rst_n_in` = 0, asynchronous, any state):
  - State goes to IDLE.
  - `busy_out`, `done_out`, `div_by_zero_out` = 0; `quotient_out`, `remainder_out` = 0.
  - Iteration counter and working registers are cleared.
  - Reset mid-CALC abandons the operation with no `done_out`.
- States are IDLE, CALC and DONE.
- IDLE:
  - `start_in` = 1 at edge E0 latches the operands.
  - If the divisor is non-zero, go to CALC: `busy_out` = 1, counter = 0, working Q = dividend, working R = 0 (WIDTH+1 bits).
  - If the divisor is 0, go directly to DONE: `quotient_out` = all ones, `remainder_out` = dividend, `div_by_zero_out` = 1.
- CALC, one iteration per edge E1..E(WIDTH):
  - R = {R[WIDTH-1:0], Q[WIDTH-1]}; Q = Q << 1.
  - T = R + ~{1'b0, D} + 1, computed (WIDTH+1) bits wide.
  - If T[WIDTH] = 0, then R = T and Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
  - Counter increments each edge.
  - On edge E(WIDTH), go to DONE:
    - `quotient_out` = final Q and `remainder_out` = R[WIDTH-1:0].
    - `div_by_zero_out` = 0.
    - `busy_out` = 0.
- DONE:
  - `done_out` = 1 for exactly this one cycle.
  - On the next edge: if `start_in` = 1, accept a new operation (same rules as IDLE, back-to-back); otherwise go to IDLE.
- Latency: `done_out` is high during the cycle following edge E(WIDTH), which is WIDTH cycles after acceptance. For divide-by-zero, `done_out` is high in the cycle following E0.
- Throughput: one result per WIDTH+1 cycles with `start_in` held high.
- `start_in` during CALC is ignored; operands are not re-sampled and the in-flight result is unaffected.
- Input changes after E0 have no effect on the in-flight operation.
- Outputs hold their last results in IDLE and CALC. They update only on entry to DONE.
- Arithmetic: the quotient never exceeds WIDTH bits; the remainder is always less than the divisor (non-zero divisor case).

Test Plan:
1. Reset, then start with 13 / 3 (WIDTH = 4) → `busy_out` high 4 cycles; `done_out` pulse 4 cycles after the accepting edge; `quotient_out` = 0100, `remainder_out` = 0001, `div_by_zero_out` = 0.
2. Sweep: 15 / 1 → q = 1111, r = 0000; 7 / 9 → q = 0000, r = 0111; 15 / 15 → q = 0001, r = 0000; 0 / 5 → q = 0000, r = 0000.
3. 5 / 0 → `done_out` in the cycle after acceptance, `busy_out` never high; q = 1111, r = 0101, `div_by_zero_out` = 1. A following 6 / 2 clears `div_by_zero_out`, giving q = 0011, r = 0000.
4. Start 12 / 5, then pulse `start_in` with 9 / 1 on the 2nd CALC cycle → the second request is ignored; result q = 0010, r = 0010; exactly one `done_out`.
5. Start 14 / 3; assert `rst_n_in` low asynchronously mid-CALC → all outputs 0 immediately, no `done_out`. After release, 14 / 3 completes with q = 0100, r = 0010.
6. `start_in` held high with operands 9 / 2 then 11 / 4 presented in the DONE cycle → back-to-back results q = 0100, r = 0001 then q = 0010, r = 0011; `done_out` pulses spaced exactly 5 cycles apart.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider.
// One quotient bit is produced per clock using a trial subtract (A + ~B + 1).
// A start/done handshake controls it, and the results are held between completions.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start_in; results hold the last completion
//   CALC  | one restoring iteration per edge, busy_out high
//   DONE  | results just updated, done_out high for this one cycle
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_by_zero_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_work;
    // The remainder held between iterations is always below the divisor,
    // so WIDTH bits are enough. Only the shifted trial value needs WIDTH+1.
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] d_reg;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: shift in the next dividend bit, then trial-subtract the divisor.
    always_comb begin
        r_shift = {r_work, q_work[WIDTH-1]};
        q_shift = {q_work[WIDTH-2:0], 1'b0};
        trial   = r_shift + ~{1'b0, d_reg} + ONE_EXT;
        r_next  = r_shift[WIDTH-1:0];
        q_next  = q_shift;
        if (!trial[WIDTH]) begin
            r_next = trial[WIDTH-1:0];
            q_next = q_shift | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic and the state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done_out = (state == ST_DONE);
                if (start_in) begin
                    accept    = 1'b1;
                    state_nxt = (divisor_in == '0) ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                busy_out  = 1'b1;
                last_iter = (cnt == CNT_LAST);
                if (last_iter) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand latch, iteration registers and result registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt             <= '0;
            q_work          <= '0;
            r_work          <= '0;
            d_reg           <= '0;
            quotient_out    <= '0;
            remainder_out   <= '0;
            div_by_zero_out <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            q_work <= dividend_in;
            r_work <= '0;
            d_reg  <= divisor_in;
            if (divisor_in == '0) begin
                quotient_out    <= '1;
                remainder_out   <= dividend_in;
                div_by_zero_out <= 1'b1;
            end
        end else if (state == ST_CALC) begin
            cnt    <= cnt + CNT_W'(1);
            q_work <= q_next;
            r_work <= r_next;
            if (last_iter) begin
                quotient_out    <= q_next;
                remainder_out   <= r_next;
                div_by_zero_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus hand-written handshake sequences.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         start_in;
    logic [W-1:0] dividend_in;
    logic [W-1:0] divisor_in;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] quotient_out;
    logic [W-1:0] remainder_out;
    logic         div_by_zero_out;

    int n_pass = 0;
    int n_total = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .start_in        (start_in),
        .dividend_in     (dividend_in),
        .divisor_in      (divisor_in),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .quotient_out    (quotient_out),
        .remainder_out   (remainder_out),
        .div_by_zero_out (div_by_zero_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           done_idx;   // negedge index after the accepting edge where done appears
        int           busy_cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Launch one operation and observe 8 cycles: busy/done counts, done position, results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int done_idx, output int busy_cyc, output int done_cnt,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
        done_idx = -1; busy_cyc = 0; done_cnt = 0; q = '0; r = '0; dbz = 1'b0;
        @(negedge clk_in);
        dividend_in = a; divisor_in = b; start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
        dividend_in = ~a; divisor_in = ~b;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_in);
            if (busy_out) busy_cyc++;
            if (done_out) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx = i; q = quotient_out; r = remainder_out; dbz = div_by_zero_out;
                end
            end
        end
    endtask

    initial begin
        int di, bc, dc, d1, d2, q1, r1, q2, r2;
        logic [W-1:0] q, r;
        logic dbz;

        vecs[0] = '{4'd13, 4'd3,  4'b0100, 4'b0001, 1'b0, 5, 4};
        vecs[1] = '{4'd15, 4'd1,  4'b1111, 4'b0000, 1'b0, 5, 4};
        vecs[2] = '{4'd7,  4'd9,  4'b0000, 4'b0111, 1'b0, 5, 4};
        vecs[3] = '{4'd15, 4'd15, 4'b0001, 4'b0000, 1'b0, 5, 4};
        vecs[4] = '{4'd0,  4'd5,  4'b0000, 4'b0000, 1'b0, 5, 4};
        vecs[5] = '{4'd5,  4'd0,  4'b1111, 4'b0101, 1'b1, 1, 0};
        vecs[6] = '{4'd6,  4'd2,  4'b0011, 4'b0000, 1'b0, 5, 4};

        rst_n_in = 1'b0; start_in = 1'b0; dividend_in = '0; divisor_in = '0;
        #12;
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_q", quotient_out, 0);
        check("rst_r", remainder_out, 0);
        check("rst_dbz", div_by_zero_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k].a, vecs[k].b, di, bc, dc, q, r, dbz);
            check($sformatf("v%0d_q", k), q, vecs[k].q);
            check($sformatf("v%0d_r", k), r, vecs[k].r);
            check($sformatf("v%0d_dbz", k), dbz, vecs[k].dbz);
            check($sformatf("v%0d_done_idx", k), di, vecs[k].done_idx);
            check($sformatf("v%0d_busy_cyc", k), bc, vecs[k].busy_cyc);
            check($sformatf("v%0d_done_cnt", k), dc, 1);
        end

        // start_in during CALC is ignored.
        dc = 0; q1 = -1; r1 = -1;
        @(negedge clk_in);
        dividend_in = 4'd12; divisor_in = 4'd5; start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_in);
            if (i == 2) begin start_in = 1'b1; dividend_in = 4'd9; divisor_in = 4'd1; end
            if (i == 3) start_in = 1'b0;
            if (done_out) begin dc++; q1 = quotient_out; r1 = remainder_out; end
        end
        check("ign_q", q1, 2);
        check("ign_r", r1, 2);
        check("ign_done_cnt", dc, 1);
        check("ign_hold_q", quotient_out, 2);
        check("ign_hold_r", remainder_out, 2);

        // Asynchronous reset mid-CALC.
        @(negedge clk_in);
        dividend_in = 4'd14; divisor_in = 4'd3; start_in = 1'b1;
        @(posedge clk_in);
        #1 start_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("mid_busy_before", busy_out, 1);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_busy", busy_out, 0);
        check("arst_done", done_out, 0);
        check("arst_q", quotient_out, 0);
        check("arst_r", remainder_out, 0);
        check("arst_dbz", div_by_zero_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        dc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            if (done_out) dc++;
        end
        check("arst_no_done", dc, 0);
        run_op(4'd14, 4'd3, di, bc, dc, q, r, dbz);
        check("arst_rerun_q", q, 4);
        check("arst_rerun_r", r, 2);
        check("arst_rerun_done_idx", di, 5);

        // Back-to-back with start_in held high.
        d1 = -1; d2 = -1; q1 = -1; r1 = -1; q2 = -1; r2 = -1;
        @(negedge clk_in);
        dividend_in = 4'd9; divisor_in = 4'd2; start_in = 1'b1;
        @(posedge clk_in);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk_in);
            if (done_out) begin
                if (d1 < 0) begin
                    d1 = i; q1 = quotient_out; r1 = remainder_out;
                    dividend_in = 4'd11; divisor_in = 4'd4;
                end else if (d2 < 0) begin
                    d2 = i; q2 = quotient_out; r2 = remainder_out;
                    start_in = 1'b0;
                end
            end
        end
        start_in = 1'b0;
        check("b2b_q1", q1, 4);
        check("b2b_r1", r1, 1);
        check("b2b_q2", q2, 2);
        check("b2b_r2", r2, 3);
        check("b2b_first_idx", d1, 5);
        check("b2b_spacing", d2 - d1, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish, expected finish before 20000");
        $fatal(1);
    end

endmodule
